// File: rtl/lc3_pkg.sv
// Shared types and widths for the LC-3 memory access controller.
package lc3_pkg;

   localparam int LC3_ADDR_W = 16;
   localparam int LC3_DATA_W = 16;
   localparam int CNT_W      = 4;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      WAIT,
      DONE
   } mem_state_t;

endpackage

// File: rtl/lc3_wait_cnt.sv
// Loadable 4-bit down-counter that paces the RAM wait states.
module lc3_wait_cnt
   import lc3_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             dec,
   input  logic [CNT_W-1:0] load_val,
   output logic             zero
);

   logic [CNT_W-1:0] cnt;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/lc3_mem_ctrl.sv
// Request/response front end to the synchronous LC-3 RAM: fetch and LD/ST accesses,
// programmable wait states and out-of-range detection.
module lc3_mem_ctrl
   import lc3_pkg::*;
#(
   parameter int ADDR_W      = LC3_ADDR_W,
   parameter int DATA_W      = LC3_DATA_W,
   parameter int MEM_WORDS   = 65536,
   parameter int WAIT_STATES = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              req_ready,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   // One extra bit so MEM_WORDS == 2**ADDR_W is representable and never flags.
   localparam logic [ADDR_W:0]    ADDR_LIMIT = (ADDR_W + 1)'(MEM_WORDS);
   localparam logic [CNT_W-1:0]   WAIT_LOAD  = CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

   mem_state_t        state, state_nx;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q, rdata_q, rdata_nx;
   logic              we_q, err_q;
   logic              accept, in_range, cnt_load, cnt_dec, cnt_zero;

   assign in_range = ({1'b0, req_addr} < ADDR_LIMIT);

   lc3_wait_cnt u_wait_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_load),
      .dec      (cnt_dec),
      .load_val (WAIT_LOAD),
      .zero     (cnt_zero)
   );

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_nx  = state;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      rsp_err   = 1'b0;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      cnt_load  = 1'b0;
      cnt_dec   = 1'b0;
      rdata_nx  = rdata_q;
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
      busy      = (state != IDLE);
      case (state)
         IDLE: begin
            req_ready = rst;
         end
         ACCESS: begin
            mem_en   = 1'b1;
            mem_we   = we_q;
            cnt_load = (WAIT_STATES != 0);
            state_nx = (WAIT_STATES == 0) ? DONE : WAIT;
         end
         WAIT: begin
            cnt_dec = !cnt_zero;
            if (cnt_zero) state_nx = DONE;
         end
         DONE: begin
            req_ready = rst;
            rsp_valid = 1'b1;
            rsp_err   = err_q;
            if (!we_q) rdata_nx = err_q ? '0 : mem_rdata;
            state_nx  = IDLE;
         end
         default: state_nx = IDLE;
      endcase
      // Ready is only raised in IDLE/DONE, so a handshake always restarts the access.
      accept = req_valid && req_ready;
      if (accept) state_nx = in_range ? ACCESS : DONE;
      rsp_rdata = rdata_nx;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         state   <= state_nx;
         rdata_q <= rdata_nx;
         if (accept) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            we_q    <= req_we;
            err_q   <= !in_range;
         end
      end
   end

endmodule
